// File: rtl/reg_bank_pkg.sv
// Register map and shared constants for the AXI control/status register bank.
package reg_bank_pkg;
  localparam int unsigned REG_ID      = 0;
  localparam int unsigned REG_CTRL    = 1;
  localparam int unsigned REG_STATUS  = 2;
  localparam int unsigned REG_IRQ_EN  = 3;
  localparam int unsigned REG_SCRATCH = 4;
  localparam int unsigned REG_CYC_LO  = 5;
  localparam int unsigned REG_CYC_HI  = 6;
  localparam int unsigned REG_GP_BASE = 8;

  localparam logic [31:0] DEFAULT_ID = 32'h1234_5678;
endpackage

// File: rtl/sticky_status.sv
// Sticky event bits with write-one-to-clear; a set in the same cycle beats the clear.
module sticky_status #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] set,
  input  logic [N-1:0] clr,
  input  logic         clr_en,
  output logic [N-1:0] status
);
  always_ff @(posedge clk) begin
    if (reset) status <= '0;
    else       status <= (status & ~(clr & {N{clr_en}})) | set;
  end
endmodule

// File: rtl/axi_reg_bank.sv
// Control/status register bank driven by the axi_registers read/write strobes.
module axi_reg_bank
  import reg_bank_pkg::*;
#(
  parameter int          NREGS         = 16,
  parameter int          NEVENTS       = 8,
  parameter logic [31:0] ID_VALUE      = DEFAULT_ID,
  parameter logic [31:0] CTRL_RESET    = 32'h0,
  parameter logic [31:0] SCRATCH_RESET = 32'haabbccdd,
  localparam int         RWIDTH        = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RWIDTH-1:0]  i_rreg,
  input  logic [RWIDTH-1:0]  i_wreg,
  input  logic [31:0]        i_wdata,
  input  logic               i_rd,
  input  logic               i_wr,
  output logic [31:0]        o_rdata,
  output logic [31:0]        o_ctrl,
  output logic               o_ctrl_strobe,
  input  logic [NEVENTS-1:0] i_event,
  output logic               o_irq
);
  logic [31:0]        ridx, widx;
  logic [NEVENTS-1:0] status, irq_en;
  logic [31:0]        scratch, cyc_hi;
  logic [63:0]        cnt;
  logic [31:0]        gp [NREGS];

  assign ridx = 32'(i_rreg);
  assign widx = 32'(i_wreg);

  sticky_status #(.N(NEVENTS)) u_status (
    .clk    (clk),
    .reset  (reset),
    .set    (i_event),
    .clr    (i_wdata[NEVENTS-1:0]),
    .clr_en (i_wr && widx == REG_STATUS),
    .status (status)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      o_ctrl        <= CTRL_RESET;
      o_ctrl_strobe <= 1'b0;
      irq_en        <= '0;
      scratch       <= SCRATCH_RESET;
      cyc_hi        <= '0;
      cnt           <= '0;
      o_irq         <= 1'b0;
      for (int i = 0; i < NREGS; i++) gp[i] <= '0;
    end else begin
      o_ctrl_strobe <= 1'b0;
      if (i_wr) begin
        case (widx)
          REG_CTRL:    begin o_ctrl <= i_wdata; o_ctrl_strobe <= 1'b1; end
          REG_IRQ_EN:  irq_en  <= i_wdata[NEVENTS-1:0];
          REG_SCRATCH: scratch <= i_wdata;
          default:     if (widx >= REG_GP_BASE) gp[i_wreg] <= i_wdata;
        endcase
      end
      // Low-word load keeps the high word; otherwise free-run and wrap
      if (i_wr && widx == REG_CYC_LO) cnt <= {cnt[63:32], i_wdata};
      else                            cnt <= cnt + 64'd1;
      // Snapshot the pre-edge high word so it pairs with the low word just read
      if (i_rd && ridx == REG_CYC_LO) cyc_hi <= cnt[63:32];
      o_irq <= |(status & irq_en);
    end
  end

  always_comb begin
    o_rdata = '0;
    case (ridx)
      REG_ID:      o_rdata = ID_VALUE;
      REG_CTRL:    o_rdata = o_ctrl;
      REG_STATUS:  o_rdata[NEVENTS-1:0] = status;
      REG_IRQ_EN:  o_rdata[NEVENTS-1:0] = irq_en;
      REG_SCRATCH: o_rdata = scratch;
      REG_CYC_LO:  o_rdata = cnt[31:0];
      REG_CYC_HI:  o_rdata = cyc_hi;
      default:     if (ridx >= REG_GP_BASE) o_rdata = gp[i_rreg];
    endcase
  end
endmodule

// File: doc/axi_reg_bank.md
# axi_reg_bank

Parametrised control/status register bank that sits behind `axi_registers` on the GP0 control path. It replaces per-design ad-hoc register case statements with:
- a fixed register map (ID, control, sticky W1C status with interrupt, scratch, 64-bit cycle counter with atomic high-word snapshot);
- a configurable array of general-purpose RW registers.

It consumes the `axi_registers` read/write strobe interface directly.

## Interface
Parameters:
- `NREGS`, 16: number of 32-bit registers; power of two, minimum 16.
- `RWIDTH`, `$clog2(NREGS)`: register index width (derived, not overridden).
- `NEVENTS`, 8: status/event bits, 1..32.
- `ID_VALUE`, 32'h12345678: value returned by register 0.
- `CTRL_RESET`, 32'h0: reset value of CTRL.
- `SCRATCH_RESET`, 32'haabbccdd: reset value of SCRATCH.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: register clock (the AXI clock).
- `reset` in 1: synchronous, active-high.
- `i_rreg` in RWIDTH: read register index.
- `i_wreg` in RWIDTH: write register index.
- `i_wdata` in 32: write data.
- `i_rd` in 1: read strobe, one cycle per AXI read.
- `i_wr` in 1: write strobe, one cycle per AXI write.
- `o_rdata` out 32: read data, combinational on `i_rreg`.
- `o_ctrl` out 32: current CTRL value.
- `o_ctrl_strobe` out 1: one-cycle pulse following any CTRL write.
- `i_event` in NEVENTS: event pulses, one sticky status bit per event.
- `o_irq` out 1: registered interrupt request.

## Operation
Register map (index: name, behaviour):
- 0 ID: RO, `ID_VALUE`; writes ignored.
- 1 CTRL: RW, reset `CTRL_RESET`.
- 2 STATUS: W1C sticky, NEVENTS bits, upper bits read 0.
  - Bit n sets when `i_event[n]`=1.
  - Bit n clears on a write to 2 with `i_wdata[n]`=1.
  - Set wins over a clear in the same cycle.
- 3 IRQ_EN: RW, NEVENTS bits, reset 0; upper bits read 0, writes to them ignored.
- 4 SCRATCH: RW, reset `SCRATCH_RESET`.
- 5 CYC_LO: reads counter[31:0].
  - Write loads counter[31:0] and leaves [63:32] unchanged.
  - A read (`i_rd` with `i_rreg`=5) latches counter[63:32] into CYC_HI.
- 6 CYC_HI: RO snapshot register, reset 0; writes ignored.
- 7: reserved, reads 0, writes ignored.
- 8..NREGS-1 GP: RW, reset 0.

Counter:
- 64-bit, increments by 1 every cycle when not loaded.
- Wraps 2^64-1 -> 0.
- Reset value is 0.

Interrupt: `o_irq` <= |(STATUS & IRQ_EN), registered.

## Timing
- Reset values: `o_ctrl`=`CTRL_RESET`, `o_ctrl_strobe`=0, `o_irq`=0, STATUS=0, counter=0.
- `o_rdata` is combinational from `i_rreg` and the current register state, with zero added latency; `axi_registers` samples it together with `i_rd`.
- Writes take effect at the edge where `i_wr`=1; readable from the next cycle.
- `o_ctrl_strobe` is high exactly in the cycle after the CTRL write edge, alongside the new `o_ctrl` value.
- `i_event[n]` high at edge k: STATUS bit readable at k+1; `o_irq` high at k+2 if enabled.
- Clearing STATUS or IRQ_EN at edge k: `o_irq` falls at k+2.
- CYC_LO write at edge k: counter = `i_wdata` at k+1, then increments from there.
- Snapshot consistency: CYC_HI holds the high word of the same counter value returned by CYC_LO in the `i_rd` cycle; low-word carry between the two reads cannot tear.
- Simultaneous CYC_LO read and write: snapshot captures the pre-write counter.
- `i_rd` with any other index has no side effect.
- `reset` asserted mid-operation: all state returns to reset values at the next edge. `i_wr`, `i_rd` and `i_event` are ignored in the reset cycle.

## Structure
- Package `reg_bank_pkg`: localparams `REG_ID`, `REG_CTRL`, `REG_STATUS`, `REG_IRQ_EN`, `REG_SCRATCH`, `REG_CYC_LO`, `REG_CYC_HI`, `REG_GP_BASE`=8, and the default ID constant.
- Sub-module `sticky_status` (param `N`):
  - inputs: `clk`, `reset`, set vector, clear vector, clear enable;
  - output: status vector;
  - set-priority rule lives here.
- Counter, snapshot, GP array and read mux are inline.

## Test plan
- Reset, then read all indices -> 0: 12345678; 1: 0; 2: 0; 4: aabbccdd; 6: 0; 7: 0; GP: 0; `o_irq`=0.
- Write CTRL=0x5 -> `o_ctrl`=5 and `o_ctrl_strobe`=1 for exactly one cycle; write index 0 = 0xffffffff -> still reads 12345678.
- Status and interrupt:
  - Pulse `i_event[3]`, IRQ_EN=0x08 -> STATUS=0x08, `o_irq` high 2 cycles after the event.
  - Write STATUS=0x08 in the same cycle as another `i_event[3]` -> bit stays set.
  - Write STATUS=0x08 alone -> bit clears, `o_irq` low 2 cycles later.
- Counter wrap and snapshot: write CYC_LO=0xfffffffe, read CYC_LO at counter 0x0_ffffffff -> rdata ffffffff. Next-cycle CYC_HI read returns 0, not 1, while the live counter is 0x1_00000000.
- GP and mid-operation reset:
  - Write GP index NREGS-1 = 0xdeadbeef and read it back.
  - Assert `reset` with `i_wr` to SCRATCH in the same cycle -> SCRATCH=aabbccdd and GP=0 after reset.
- Run with NREGS=32, NEVENTS=32: event bit 31 W1C works; GP index 31 reads back a written value.
